// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: two-state fetch/exec controller that owns the PC, latches instructions
// from the I-cache, holds commit on data-memory stalls and resolves jump/branch targets.
module instr_fetch_sequencer #(
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic [PC_WIDTH-1:0] IMEM_ADDRESS,
    output logic                IMEM_READ,
    input  logic [31:0]         IMEM_READDATA,
    input  logic                IMEM_BUSYWAIT,
    input  logic                DMEM_BUSYWAIT,
    output logic [31:0]         INSTRUCTION,
    output logic                INSTR_VALID,
    output logic                COMMIT,
    output logic [PC_WIDTH-1:0] PC,
    input  logic                JUMP_CONTROL,
    input  logic [1:0]          BRANCH_CONTROL,
    input  logic                ZERO,
    input  logic [7:0]          OFFSET,
    output logic [31:0]         INSTR_COUNT
);
    typedef enum logic {FETCH, EXEC} state_t;
    state_t state, state_nx;
    logic [PC_WIDTH-1:0] pc_q, next_pc, off_ext;
    logic [31:0] instr_q, count_q;
    logic taken, retire;
    always_comb begin
        taken = JUMP_CONTROL | (BRANCH_CONTROL == 2'b01 & ZERO) | (BRANCH_CONTROL == 2'b10 & !ZERO);
        off_ext = {{(PC_WIDTH-10){OFFSET[7]}}, OFFSET, 2'b00};
        next_pc = pc_q + PC_WIDTH'(4) + (taken ? off_ext : '0);
        retire = state == EXEC && !DMEM_BUSYWAIT;
        state_nx = state;
        if (state == FETCH && !IMEM_BUSYWAIT) state_nx = EXEC;
        else if (retire) state_nx = FETCH;
        // Handshake outputs are forced low while reset is held.
        IMEM_READ = state == FETCH && !RESET;
        INSTR_VALID = state == EXEC && !RESET;
        COMMIT = retire && !RESET;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= FETCH;
            pc_q <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH && !IMEM_BUSYWAIT) instr_q <= IMEM_READDATA;
            if (retire) begin
                pc_q <= next_pc;
                count_q <= count_q + 32'd1;
            end
        end
    end
    assign IMEM_ADDRESS = pc_q;
    assign PC = pc_q;
    assign INSTRUCTION = instr_q;
    assign INSTR_COUNT = count_q;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: table vectors, hand sequences and randomized instruction stream
// checked against a transaction-level model of PC, instruction and retire count.
module tb_instr_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_address, imem_readdata, instruction, pc, instr_count;
    logic        imem_read, imem_busywait, dmem_busywait, instr_valid, commit;
    logic        jump_control, zero;
    logic [1:0]  branch_control;
    logic [7:0]  offset;

    int vectors = 0;
    int fails = 0;
    logic [31:0] m_pc, m_cnt, m_instr;

    typedef struct {
        logic [31:0] start;
        logic        j;
        logic [1:0]  br;
        logic        z;
        logic [7:0]  off;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[7];

    instr_fetch_sequencer dut (
        .CLK(clk), .RESET(rst),
        .IMEM_ADDRESS(imem_address), .IMEM_READ(imem_read),
        .IMEM_READDATA(imem_readdata), .IMEM_BUSYWAIT(imem_busywait),
        .DMEM_BUSYWAIT(dmem_busywait),
        .INSTRUCTION(instruction), .INSTR_VALID(instr_valid), .COMMIT(commit), .PC(pc),
        .JUMP_CONTROL(jump_control), .BRANCH_CONTROL(branch_control),
        .ZERO(zero), .OFFSET(offset), .INSTR_COUNT(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic j,
                                             input logic [1:0] br, input logic z,
                                             input logic [7:0] off);
        int s;
        bit tk;
        s = int'($signed(off));
        tk = j || (br == 2'd1 && z) || (br == 2'd2 && !z);
        return p + 32'd4 + (tk ? 32'(s * 4) : 32'd0);
    endfunction

    task automatic scramble_ctrl();
        jump_control = 1'($urandom);
        branch_control = 2'($urandom);
        zero = 1'($urandom);
        offset = 8'($urandom);
    endtask

    task automatic do_reset(input logic dm);
        @(negedge clk);
        rst = 1'b1;
        imem_busywait = 1'b1;
        dmem_busywait = dm;
        #1;
        chk("rst_imem_read", 32'(imem_read), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_pc = 32'd0;
        m_cnt = 32'd0;
        m_instr = 32'd0;
        chk("rst_pc", pc, m_pc);
        chk("rst_count", instr_count, m_cnt);
        chk("rst_instr", instruction, m_instr);
        chk("rst_first_read", 32'(imem_read), 32'd1);
        chk("rst_state_fetch", 32'(instr_valid), 32'd0);
    endtask

    // One instruction: iw I-cache wait cycles, dw D-memory stall cycles, then commit.
    task automatic run_instr(input int iw, input int dw, input logic j, input logic [1:0] br,
                             input logic z, input logic [7:0] off, input logic [31:0] word);
        for (int c = 0; c <= iw; c++) begin
            @(negedge clk);
            imem_busywait = (c < iw);
            imem_readdata = (c < iw) ? $urandom : word;
            dmem_busywait = 1'($urandom);
            scramble_ctrl();
            #1;
            chk("f_read", 32'(imem_read), 32'd1);
            chk("f_addr", imem_address, m_pc);
            chk("f_valid", 32'(instr_valid), 32'd0);
            chk("f_commit", 32'(commit), 32'd0);
            chk("f_instr_hold", instruction, m_instr);
        end
        m_instr = word;
        for (int c = 0; c <= dw; c++) begin
            @(negedge clk);
            dmem_busywait = (c < dw);
            imem_busywait = 1'($urandom);
            imem_readdata = $urandom;
            if (c < dw) scramble_ctrl();
            else begin
                jump_control = j;
                branch_control = br;
                zero = z;
                offset = off;
            end
            #1;
            chk("e_read", 32'(imem_read), 32'd0);
            chk("e_valid", 32'(instr_valid), 32'd1);
            chk("e_commit", 32'(commit), 32'(c == dw));
            chk("e_instr", instruction, m_instr);
            chk("e_pc", pc, m_pc);
            chk("e_count", instr_count, m_cnt);
        end
        m_pc = ref_next(m_pc, j, br, z, off);
        m_cnt = m_cnt + 32'd1;
    endtask

    initial begin
        tbl[0] = '{32'h10,       1'b0, 2'b01, 1'b1, 8'hFE, 32'h0000000C};
        tbl[1] = '{32'h10,       1'b0, 2'b01, 1'b0, 8'hFE, 32'h00000014};
        tbl[2] = '{32'h10,       1'b0, 2'b10, 1'b0, 8'h02, 32'h0000001C};
        tbl[3] = '{32'hFFFFFFFC, 1'b1, 2'b00, 1'b0, 8'h7F, 32'h000001FC};
        tbl[4] = '{32'h10,       1'b0, 2'b11, 1'b1, 8'h05, 32'h00000014};
        tbl[5] = '{32'h10,       1'b0, 2'b10, 1'b1, 8'h05, 32'h00000014};
        tbl[6] = '{32'h10,       1'b1, 2'b01, 1'b0, 8'h80, 32'hFFFFFE14};
        imem_busywait = 1'b1;
        dmem_busywait = 1'b0;
        imem_readdata = 32'd0;
        scramble_ctrl();

        do_reset(1'b0);
        for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 2'b00, 1'b0, 8'h00, $urandom);
        @(negedge clk);
        imem_busywait = 1'b1;
        #1;
        chk("seq_count3", instr_count, 32'd3);
        chk("seq_addr12", imem_address, 32'd12);

        do_reset(1'b0);
        run_instr(3, 0, 1'b0, 2'b00, 1'b0, 8'h00, 32'hCAFE0001);
        run_instr(0, 2, 1'b0, 2'b10, 1'b0, 8'h03, 32'hCAFE0002);

        // Reset with an instruction stalled in EXEC must discard it.
        run_instr(0, 0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h12345678);
        @(negedge clk);
        imem_busywait = 1'b0;
        imem_readdata = 32'hDEADBEEF;
        dmem_busywait = 1'b1;
        @(negedge clk);
        dmem_busywait = 1'b1;
        #1;
        chk("mid_valid", 32'(instr_valid), 32'd1);
        chk("mid_instr", instruction, 32'hDEADBEEF);
        do_reset(1'b1);

        foreach (tbl[k]) begin
            do_reset(1'b0);
            if (tbl[k].start != 32'd0)
                run_instr(0, 0, 1'b1, 2'b00, 1'b0, 8'((tbl[k].start - 32'd4) >> 2), $urandom);
            run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      tbl[k].j, tbl[k].br, tbl[k].z, tbl[k].off, $urandom);
            @(negedge clk);
            imem_busywait = 1'b1;
            #1;
            chk("tbl_pc", pc, tbl[k].exp_pc);
            chk("tbl_count", instr_count, (tbl[k].start != 32'd0) ? 32'd2 : 32'd1);
        end

        do_reset(1'b0);
        for (int i = 0; i < 200; i++)
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      ($urandom % 6) == 0, 2'($urandom), 1'($urandom), 8'($urandom), $urandom);
        @(negedge clk);
        imem_busywait = 1'b1;
        #1;
        chk("rand_pc", pc, m_pc);
        chk("rand_count", instr_count, 32'd200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
